// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin arbiter: two 8-bit AXI-Stream requesters onto one MAC tx stream,
// with header capture and inter-frame gap. Define ETH_TX_ARB_TIMEOUT_EN for the stall watchdog.
module eth_tx_arbiter #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  input  logic        s0_axis_tuser,
  output logic        s0_axis_tready,
  input  logic [47:0] s0_dst_mac,
  input  logic [15:0] s0_eth_type,
  input  logic [7:0]  s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  input  logic        s1_axis_tuser,
  output logic        s1_axis_tready,
  input  logic [47:0] s1_dst_mac,
  input  logic [15:0] s1_eth_type,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [47:0] dst_mac,
  output logic [15:0] eth_type,
  output logic [1:0]  grant,
  output logic        busy
);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

`ifdef ETH_TX_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, XFER, GAP, DROP} state_e;
`else
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_e;
`endif

  state_e          state_q;
  logic [1:0]      grant_q;
  logic            rr_q;
  logic            busy_q;
  logic [47:0]     mac_q;
  logic [15:0]     typ_q;
  logic [GW-1:0]   gap_q;

  // View of whichever requester currently owns the stream
  logic       sel;
  logic [7:0] src_data;
  logic       src_valid, src_last, src_user;
  logic       src_rdy;
  logic       pick;
  logic       flush;
  logic       frame_end;

  assign sel       = grant_q[1];
  assign src_data  = sel ? s1_axis_tdata  : s0_axis_tdata;
  assign src_valid = sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign src_last  = sel ? s1_axis_tlast  : s0_axis_tlast;
  assign src_user  = sel ? s1_axis_tuser  : s0_axis_tuser;

  // rr_q names the requester that wins a tie
  assign pick = (s0_axis_tvalid & s1_axis_tvalid) ? rr_q : s1_axis_tvalid;

`ifdef ETH_TX_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] stall_q;
  logic          flush_q;
  assign flush = flush_q;

  // flush_q: the source starved the MAC too long, emit a forced tlast beat
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_q <= '0;
      flush_q <= 1'b0;
    end else if (state_q != XFER) begin
      stall_q <= '0;
      flush_q <= 1'b0;
    end else if (!flush_q) begin
      if (src_valid) begin
        stall_q <= '0;
      end else if (stall_q == TW'(TIMEOUT_CYCLES - 1)) begin
        stall_q <= '0;
        flush_q <= 1'b1;
      end else begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    src_rdy       = 1'b0;
    frame_end     = 1'b0;
    if (state_q == XFER) begin
      if (flush) begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
      end else begin
        m_axis_tdata  = src_data;
        m_axis_tvalid = src_valid;
        m_axis_tlast  = src_last;
        m_axis_tuser  = src_user;
        src_rdy       = m_axis_tready;
        frame_end     = src_valid & src_last & m_axis_tready;
      end
    end
`ifdef ETH_TX_ARB_TIMEOUT_EN
    else if (state_q == DROP) begin
      src_rdy   = 1'b1;
      frame_end = src_valid & src_last;
    end
`endif
  end

  assign s0_axis_tready = grant_q[0] & src_rdy;
  assign s1_axis_tready = grant_q[1] & src_rdy;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      rr_q    <= 1'b0;
      busy_q  <= 1'b0;
      mac_q   <= '0;
      typ_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s0_axis_tvalid | s1_axis_tvalid) begin
            grant_q <= pick ? 2'b10 : 2'b01;
            mac_q   <= pick ? s1_dst_mac  : s0_dst_mac;
            typ_q   <= pick ? s1_eth_type : s0_eth_type;
            busy_q  <= 1'b1;
            state_q <= XFER;
          end
        end
`ifdef ETH_TX_ARB_TIMEOUT_EN
        XFER, DROP: begin
`else
        XFER: begin
`endif
          if (frame_end) begin
            grant_q <= 2'b00;
            rr_q    <= ~sel;
            if (IFG_CYCLES == 0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              gap_q   <= GW'(IFG_CYCLES - 1);
              state_q <= GAP;
            end
          end
`ifdef ETH_TX_ARB_TIMEOUT_EN
          else if (state_q == XFER && flush && m_axis_tready) begin
            state_q <= DROP;
          end
`endif
        end
        GAP: begin
          if (gap_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign dst_mac  = mac_q;
  assign eth_type = typ_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench for eth_tx_arbiter: per-source frame FIFOs as the reference,
// round-robin order and inter-frame gap derived from the arbitration rules.
module tb_eth_tx_arbiter;
  localparam int IFG = 12;

  typedef struct packed {
    logic [1:0]  g;
    logic [7:0]  d;
    logic        l;
    logic        u;
    logic [47:0] mac;
    logic [15:0] typ;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  sd[2];
  logic        sv[2], sl[2], su[2];
  logic [47:0] smac[2];
  logic [15:0] styp[2];
  logic        m_rdy = 1'b0;
  logic        rdy_rand = 1'b0;
  logic        dut_sel = 1'b0;

  logic [7:0]  a_data, b_data;
  logic        a_valid, a_last, a_user, b_valid, b_last, b_user;
  logic        a_r0, a_r1, b_r0, b_r1;
  logic [47:0] a_mac, b_mac;
  logic [15:0] a_typ, b_typ;
  logic [1:0]  a_gnt, b_gnt;
  logic        a_busy, b_busy;

  eth_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(8)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .s0_axis_tdata(sd[0]), .s0_axis_tvalid(sv[0]), .s0_axis_tlast(sl[0]), .s0_axis_tuser(su[0]),
    .s0_axis_tready(a_r0), .s0_dst_mac(smac[0]), .s0_eth_type(styp[0]),
    .s1_axis_tdata(sd[1]), .s1_axis_tvalid(sv[1]), .s1_axis_tlast(sl[1]), .s1_axis_tuser(su[1]),
    .s1_axis_tready(a_r1), .s1_dst_mac(smac[1]), .s1_eth_type(styp[1]),
    .m_axis_tdata(a_data), .m_axis_tvalid(a_valid), .m_axis_tlast(a_last), .m_axis_tuser(a_user),
    .m_axis_tready(m_rdy), .dst_mac(a_mac), .eth_type(a_typ), .grant(a_gnt), .busy(a_busy));

  eth_tx_arbiter #(.IFG_CYCLES(0), .TIMEOUT_CYCLES(8)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .s0_axis_tdata(sd[0]), .s0_axis_tvalid(sv[0]), .s0_axis_tlast(sl[0]), .s0_axis_tuser(su[0]),
    .s0_axis_tready(b_r0), .s0_dst_mac(smac[0]), .s0_eth_type(styp[0]),
    .s1_axis_tdata(sd[1]), .s1_axis_tvalid(sv[1]), .s1_axis_tlast(sl[1]), .s1_axis_tuser(su[1]),
    .s1_axis_tready(b_r1), .s1_dst_mac(smac[1]), .s1_eth_type(styp[1]),
    .m_axis_tdata(b_data), .m_axis_tvalid(b_valid), .m_axis_tlast(b_last), .m_axis_tuser(b_user),
    .m_axis_tready(m_rdy), .dst_mac(b_mac), .eth_type(b_typ), .grant(b_gnt), .busy(b_busy));

  // observed DUT (0: IFG=12 instance, 1: IFG=0 instance)
  logic [7:0]  o_data;
  logic        o_valid, o_last, o_user, o_r0, o_r1, o_busy;
  logic [47:0] o_mac;
  logic [15:0] o_typ;
  logic [1:0]  o_grant;
  assign o_data  = dut_sel ? b_data  : a_data;
  assign o_valid = dut_sel ? b_valid : a_valid;
  assign o_last  = dut_sel ? b_last  : a_last;
  assign o_user  = dut_sel ? b_user  : a_user;
  assign o_r0    = dut_sel ? b_r0    : a_r0;
  assign o_r1    = dut_sel ? b_r1    : a_r1;
  assign o_busy  = dut_sel ? b_busy  : a_busy;
  assign o_mac   = dut_sel ? b_mac   : a_mac;
  assign o_typ   = dut_sel ? b_typ   : a_typ;
  assign o_grant = dut_sel ? b_gnt   : a_gnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // frame store: [source][frame][beat]
  logic [7:0]  bd[2][16][8];
  logic        bu[2][16][8];
  int          fl[2][16];
  logic [47:0] fm[2][16];
  logic [15:0] ft[2][16];

  beat_t obs[$];
  int    obs_c[$];
  beat_t exp_q[$];
  beat_t exps[2][$];

  always @(negedge clk) begin
    #2;
    if (o_valid && m_rdy) begin
      obs.push_back({o_grant, o_data, o_last, o_user, o_mac, o_typ});
      obs_c.push_back(cyc);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rdy_rand) m_rdy = 1'($urandom);
  end

  function automatic logic rdy(input int s);
    return (s != 0) ? o_r1 : o_r0;
  endfunction

  function automatic void gen(input int s, input int n, input int lmin, input int lmax);
    for (int f = 0; f < n; f++) begin
      fl[s][f] = $urandom_range(lmax, lmin);
      fm[s][f] = {16'($urandom), $urandom};
      ft[s][f] = 16'($urandom);
      for (int i = 0; i < 8; i++) begin
        bd[s][f][i] = 8'($urandom);
        bu[s][f][i] = 1'($urandom);
      end
    end
  endfunction

  // reference: a frame leaves the arbiter intact, tagged with its owner and header
  function automatic void add_exp(input int s, input int f, input bit ordered);
    beat_t b;
    for (int i = 0; i < fl[s][f]; i++) begin
      b.g   = (s != 0) ? 2'b10 : 2'b01;
      b.d   = bd[s][f][i];
      b.l   = (i == fl[s][f] - 1);
      b.u   = bu[s][f][i];
      b.mac = fm[s][f];
      b.typ = ft[s][f];
      if (ordered) exp_q.push_back(b);
      else exps[s].push_back(b);
    end
  endfunction

  task automatic drive_src(input int s, input int f0, input int nfr, input int gapmax);
    int w;
    bit ok;
    for (int f = f0; f < f0 + nfr; f++) begin
      smac[s] = fm[s][f];
      styp[s] = ft[s][f];
      for (int i = 0; i < fl[s][f]; i++) begin
        if (i > 0) repeat ($urandom_range(gapmax, 0)) begin sv[s] = 1'b0; @(negedge clk); end
        sv[s] = 1'b1; sd[s] = bd[s][f][i]; su[s] = bu[s][f][i]; sl[s] = (i == fl[s][f] - 1);
        w = 0; ok = 1'b0;
        while (!ok && w < 3000) begin
          #1; ok = rdy(s);
          @(negedge clk); w++;
        end
        if (!ok) begin
          total++; bad++;
          $display("FAIL src%0d_handshake: ready=0 required=1 after %0d cycles", s, w);
        end
      end
    end
    sv[s] = 1'b0; sl[s] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rdy_rand = 1'b0; m_rdy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sv[s] = 0; sd[s] = 0; sl[s] = 0; su[s] = 0; smac[s] = 0; styp[s] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_rdy = 1'b1;
    obs.delete(); obs_c.delete(); exp_q.delete(); exps[0].delete(); exps[1].delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_rdy = 1'b1; dut_sel = 1'b0;
    sv[0] = 1'b1; sv[1] = 1'b1; sd[0] = 8'hA5; sl[0] = 1'b1; su[0] = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({o_valid, o_last, o_user, o_data} !== 11'h0) begin bad++;
      $display("FAIL reset_m_axis: got %h required 0", {o_valid, o_last, o_user, o_data}); end
    total++;
    if (o_grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b required 00", o_grant); end
    total++;
    if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    total++;
    if ({o_mac, o_typ} !== 64'h0) begin bad++; $display("FAIL reset_hdr: got %h required 0", {o_mac, o_typ}); end
    total++;
    if ({o_r0, o_r1} !== 2'b00) begin bad++; $display("FAIL reset_tready: got %b required 00", {o_r0, o_r1}); end
    do_reset();
  endtask

  task automatic test_single();
    int c0, n, idle_bad;
    do_reset();
    gen(0, 1, 4, 4);
    for (int i = 0; i < 4; i++) bd[0][0][i] = 8'h11 + 8'(i);
    add_exp(0, 0, 1);
    c0 = cyc;
    fork
      drive_src(0, 0, 1, 0);
      begin
        #3;
        total++;
        if (o_grant !== 2'b00) begin bad++; $display("FAIL single_pre_grant: got %b required 00", o_grant); end
        @(negedge clk); #3;
        total++;
        if ({o_grant, o_busy} !== 3'b011) begin bad++;
          $display("FAIL single_grant_latency: got grant=%b busy=%b required 01/1", o_grant, o_busy); end
      end
    join
    n = 0; idle_bad = 0;
    for (int w = 0; w < 100; w++) begin
      #3;
      if (!o_busy) break;
      if (o_valid || o_grant != 2'b00) idle_bad++;
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== IFG) begin bad++; $display("FAIL single_ifg: got %0d gap cycles required %0d", n, IFG); end
    total++;
    if (idle_bad !== 0) begin bad++; $display("FAIL single_gap_idle: got %0d active cycles required 0", idle_bad); end
    total++;
    if (obs.size() !== 4) begin bad++; $display("FAIL single_count: got %0d beats required 4", obs.size()); end
    for (int k = 0; k < obs.size() && k < 4; k++) begin
      total++;
      if (obs[k] !== exp_q[k]) begin bad++; $display("FAIL single_beat%0d: got %h required %h", k, obs[k], exp_q[k]); end
    end
    if (obs_c.size() > 0) begin
      total++;
      if (obs_c[0] !== c0 + 1) begin bad++; $display("FAIL single_first_beat: got cycle %0d required %0d", obs_c[0], c0 + 1); end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    gen(0, 4, 1, 4);
    gen(1, 4, 1, 4);
    for (int f = 0; f < 4; f++) begin fm[1][f] = 48'h0A0B0C0D0E0F; ft[1][f] = 16'h0800; end
    for (int f = 0; f < 4; f++) begin add_exp(0, f, 1); add_exp(1, f, 1); end
    fork
      drive_src(0, 0, 4, 0);
      drive_src(1, 0, 4, 0);
    join
    total++;
    if (obs.size() !== exp_q.size()) begin bad++;
      $display("FAIL rr_count: got %0d beats required %0d", obs.size(), exp_q.size()); end
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
      total++;
      if (obs[k] !== exp_q[k]) begin bad++; $display("FAIL rr_beat%0d: got %h required %h", k, obs[k], exp_q[k]); end
      if (k > 0 && obs[k-1].l) begin
        total++;
        if (obs_c[k] - obs_c[k-1] !== IFG + 2) begin bad++;
          $display("FAIL rr_gap%0d: got %0d cycles required %0d", k, obs_c[k] - obs_c[k-1], IFG + 2); end
      end
    end
  endtask

  task automatic test_mid_request();
    int leak;
    bit done;
    do_reset();
    gen(0, 1, 5, 5);
    gen(1, 1, 2, 4);
    add_exp(0, 0, 1); add_exp(1, 0, 1);
    rdy_rand = 1'b1; leak = 0; done = 1'b0;
    fork
      begin
        fork
          drive_src(0, 0, 1, 1);
          begin
            for (int w = 0; w < 500 && obs.size() < 2; w++) @(negedge clk);
            drive_src(1, 0, 1, 0);
          end
        join
        done = 1'b1;
      end
      while (!done) begin
        @(negedge clk); #3;
        if (o_grant == 2'b01 && o_r1) leak++;
      end
    join
    rdy_rand = 1'b0; m_rdy = 1'b1;
    total++;
    if (leak !== 0) begin bad++; $display("FAIL mid_s1_tready: got %0d cycles high required 0", leak); end
    total++;
    if (obs.size() !== exp_q.size()) begin bad++;
      $display("FAIL mid_count: got %0d beats required %0d", obs.size(), exp_q.size()); end
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
      total++;
      if (obs[k] !== exp_q[k]) begin bad++; $display("FAIL mid_beat%0d: got %h required %h", k, obs[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    dut_sel = 1'b1;
    gen(0, 5, 1, 1);
    for (int f = 0; f < 5; f++) add_exp(0, f, 1);
    drive_src(0, 0, 5, 0);
    @(negedge clk);
    total++;
    if (obs.size() !== 5) begin bad++; $display("FAIL b2b_count: got %0d beats required 5", obs.size()); end
    for (int k = 0; k < obs.size() && k < 5; k++) begin
      total++;
      if (obs[k] !== exp_q[k]) begin bad++; $display("FAIL b2b_beat%0d: got %h required %h", k, obs[k], exp_q[k]); end
      if (k > 0) begin
        total++;
        if (obs_c[k] - obs_c[k-1] !== 2) begin bad++;
          $display("FAIL b2b_spacing%0d: got %0d cycles required 2", k, obs_c[k] - obs_c[k-1]); end
      end
    end
    dut_sel = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    gen(0, 1, 6, 6);
    smac[0] = fm[0][0]; styp[0] = ft[0][0];
    sv[0] = 1'b1; sd[0] = 8'h21; sl[0] = 1'b0; su[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (o_grant !== 2'b01) begin bad++; $display("FAIL rstmid_pre_grant: got %b required 01", o_grant); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_valid, o_last, o_user, o_data, o_r0, o_r1} !== 13'h0) begin bad++;
      $display("FAIL rstmid_outputs: got %h required 0", {o_valid, o_last, o_user, o_data, o_r0, o_r1}); end
    total++;
    if ({o_grant, o_busy, o_mac, o_typ} !== 67'h0) begin bad++;
      $display("FAIL rstmid_state: got grant=%b busy=%b hdr=%h required 0", o_grant, o_busy, {o_mac, o_typ}); end
    sv[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    obs.delete(); obs_c.delete();
    @(negedge clk);
    gen(1, 1, 2, 4);
    add_exp(1, 0, 1);
    drive_src(1, 0, 1, 0);
    total++;
    if (obs.size() !== exp_q.size()) begin bad++;
      $display("FAIL rstmid_count: got %0d beats required %0d", obs.size(), exp_q.size()); end
    for (int k = 0; k < obs.size() && k < exp_q.size(); k++) begin
      total++;
      if (obs[k] !== exp_q[k]) begin bad++; $display("FAIL rstmid_beat%0d: got %h required %h", k, obs[k], exp_q[k]); end
    end
  endtask

  task automatic test_random_traffic();
    int ptr[2];
    int n0, n1, s;
    do_reset();
    n0 = $urandom_range(6, 3);
    n1 = $urandom_range(6, 3);
    gen(0, n0, 1, 6);
    gen(1, n1, 1, 6);
    for (int f = 0; f < n0; f++) add_exp(0, f, 0);
    for (int f = 0; f < n1; f++) add_exp(1, f, 0);
    rdy_rand = 1'b1;
    fork
      drive_src(0, 0, n0, 2);
      begin repeat ($urandom_range(20, 0)) @(negedge clk); drive_src(1, 0, n1, 2); end
    join
    rdy_rand = 1'b0; m_rdy = 1'b1;
    ptr[0] = 0; ptr[1] = 0;
    for (int k = 0; k < obs.size(); k++) begin
      s = obs[k].g[1] ? 1 : 0;
      total++;
      if (ptr[s] >= exps[s].size() || obs[k] !== exps[s][ptr[s]]) begin bad++;
        $display("FAIL rand_beat%0d: got %h required %h", k, obs[k],
                 (ptr[s] < exps[s].size()) ? exps[s][ptr[s]] : beat_t'(0)); end
      ptr[s]++;
      if (k > 0 && !obs[k-1].l) begin
        total++;
        if (obs[k].g !== obs[k-1].g) begin bad++;
          $display("FAIL rand_atomic%0d: got grant %b required %b", k, obs[k].g, obs[k-1].g); end
      end
      if (k > 0 && obs[k-1].l) begin
        total++;
        if (obs_c[k] - obs_c[k-1] < IFG + 2) begin bad++;
          $display("FAIL rand_gap%0d: got %0d cycles required >= %0d", k, obs_c[k] - obs_c[k-1], IFG + 2); end
      end
    end
    total++;
    if (ptr[0] !== exps[0].size() || ptr[1] !== exps[1].size()) begin bad++;
      $display("FAIL rand_drain: got %0d/%0d beats required %0d/%0d", ptr[0], ptr[1], exps[0].size(), exps[1].size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_request();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
